// File: rtl/ro_freq_host.sv
// ro_freq_host
//   Host-side controller for a ring-oscillator worker. Drives the worker's
//   clock_sel / mode / shift controls, counts rising edges of the worker's
//   divided oscillator output (clock_div[3]) over a fixed gate window, then
//   completes the shift/done handshake with a bounded wait.
//
//   Sequence: IDLE -> SETTLE (SETTLE cycles) -> GATE (2^GATE_LOG2 cycles)
//             -> SHIFT (1 cycle) -> WAIT (until ro_done or TIMEOUT) -> IDLE
//
// Ports
//   clk_i            system clock, the only clock
//   reset_i          synchronous active-high reset
//   start_i          measurement request, accepted only in IDLE
//   mode_in_i        worker mode, captured with an accepted start
//   busy_o           measurement in progress
//   result_o         rising-edge count of the last gate window
//   result_valid_o   result_o is valid
//   ovf_o            edge counter overflowed during the last window
//   timeout_o        ro_done was not seen within TIMEOUT cycles
//   ro_clock_sel_o   worker clock_sel
//   ro_mode_o        worker mode
//   ro_shift_o       worker shift
//   ro_div_i         worker clock_div[3], asynchronous
//   ro_done_i        worker done, asynchronous
//
// Build option
//   RO_FREQ_HOST_SAT_EN : when defined, the edge counter saturates at
//   2^CNT_W-1 instead of wrapping; ovf_o flags a blocked increment.

module ro_freq_host #(
    parameter int CNT_W       = 16,
    parameter int GATE_LOG2   = 10,
    parameter int SETTLE      = 16,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mode_in_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] result_o,
    output logic             result_valid_o,
    output logic             ovf_o,
    output logic             timeout_o,
    output logic             ro_clock_sel_o,
    output logic             ro_mode_o,
    output logic             ro_shift_o,
    input  logic             ro_div_i,
    input  logic             ro_done_i
);

    localparam int GATE_LEN = 1 << GATE_LOG2;
    // One shared timer covers the settle, gate and wait phases, so it is
    // sized for the longest of them.
    localparam int TMAX = (GATE_LEN > SETTLE)
                        ? ((GATE_LEN > TIMEOUT) ? GATE_LEN : TIMEOUT)
                        : ((SETTLE   > TIMEOUT) ? SETTLE   : TIMEOUT);
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] SETTLE_END  = TMR_W'(SETTLE - 1);
    localparam logic [TMR_W-1:0] GATE_END    = TMR_W'(GATE_LEN - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_END = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_SHIFT,
        S_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detect (run continuously)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] div_sync_q;
    logic [SYNC_STAGES-1:0] done_sync_q;
    logic                   div_hist_q;
    logic                   div_rise;
    logic                   done_s;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_sync_q  <= '0;
            done_sync_q <= '0;
            div_hist_q  <= 1'b0;
        end else begin
            div_sync_q  <= {div_sync_q[SYNC_STAGES-2:0], ro_div_i};
            done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], ro_done_i};
            div_hist_q  <= div_sync_q[SYNC_STAGES-1];
        end
    end

    assign div_rise = div_sync_q[SYNC_STAGES-1] & ~div_hist_q;
    assign done_s   = done_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Edge counter next value
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_hit;

    always_comb begin
        cnt_d   = cnt_q;
        ovf_hit = 1'b0;
        if (div_rise) begin
`ifdef RO_FREQ_HOST_SAT_EN
            if (&cnt_q) begin
                ovf_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d   = cnt_q + CNT_W'(1);
            ovf_hit = &cnt_q;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [TMR_W-1:0] tmr_q;
    logic             busy_q;
    logic [CNT_W-1:0] result_q;
    logic             result_valid_q;
    logic             ovf_q;
    logic             timeout_q;
    logic             clock_sel_q;
    logic             mode_q;
    logic             shift_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            tmr_q          <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ovf_q          <= 1'b0;
            timeout_q      <= 1'b0;
            clock_sel_q    <= 1'b0;
            mode_q         <= 1'b0;
            shift_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_q         <= mode_in_i;
                        result_q       <= '0;
                        result_valid_q <= 1'b0;
                        ovf_q          <= 1'b0;
                        timeout_q      <= 1'b0;
                        cnt_q          <= '0;
                        tmr_q          <= '0;
                        busy_q         <= 1'b1;
                        clock_sel_q    <= 1'b1;
                        state_q        <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (tmr_q == SETTLE_END) begin
                        tmr_q   <= '0;
                        state_q <= S_GATE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_GATE: begin
                    cnt_q <= cnt_d;
                    if (ovf_hit) begin
                        ovf_q <= 1'b1;
                    end
                    if (tmr_q == GATE_END) begin
                        // cnt_d already includes this cycle's edge
                        result_q    <= cnt_d;
                        tmr_q       <= '0;
                        clock_sel_q <= 1'b0;
                        shift_q     <= 1'b1;
                        state_q     <= S_SHIFT;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_SHIFT: begin
                    shift_q <= 1'b0;
                    tmr_q   <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    if (done_s) begin
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        state_q        <= S_IDLE;
                    end else if (tmr_q == TIMEOUT_END) begin
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                        timeout_q      <= 1'b1;
                        state_q        <= S_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    clock_sel_q <= 1'b0;
                    shift_q     <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign ovf_o          = ovf_q;
    assign timeout_o      = timeout_q;
    assign ro_clock_sel_o = clock_sel_q;
    assign ro_mode_o      = mode_q;
    assign ro_shift_o     = shift_q;

endmodule

// File: tb/tb_ro_freq_host.sv
// Directed bench for ro_freq_host. A main instance (CNT_W=8) and a narrow
// instance (CNT_W=4) share all inputs; the narrow one exercises overflow.
// Expected results are pushed to a scoreboard queue when a run is started
// and popped when the run completes.

module tb_ro_freq_host;

    localparam int CNT_W       = 8;
    localparam int GATE_LOG2   = 6;
    localparam int SETTLE      = 4;
    localparam int TIMEOUT     = 32;
    localparam int SYNC_STAGES = 2;
    localparam int GATE_LEN    = 1 << GATE_LOG2;
    localparam int DONE_DLY    = 3;
    // start edge through busy fall with ro_done raised DONE_DLY cycles after shift
    localparam int BUSY_RUN    = 1 + SETTLE + GATE_LEN + 1 + DONE_DLY + SYNC_STAGES;

`ifdef RO_FREQ_HOST_SAT_EN
    localparam int OVF4_RES = 15;
`else
    localparam int OVF4_RES = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, mode_in, ro_done;
    logic ro_div = 1'b0;

    logic             busy, result_valid, ovf, timeout, ro_clock_sel, ro_mode, ro_shift;
    logic [CNT_W-1:0] result;
    logic             b4_busy, b4_result_valid, b4_ovf, b4_timeout, b4_clock_sel, b4_mode, b4_shift;
    logic [3:0]       b4_result;

    ro_freq_host #(.CNT_W(CNT_W), .GATE_LOG2(GATE_LOG2), .SETTLE(SETTLE),
                   .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .mode_in_i(mode_in),
        .busy_o(busy), .result_o(result), .result_valid_o(result_valid),
        .ovf_o(ovf), .timeout_o(timeout), .ro_clock_sel_o(ro_clock_sel),
        .ro_mode_o(ro_mode), .ro_shift_o(ro_shift),
        .ro_div_i(ro_div), .ro_done_i(ro_done));

    ro_freq_host #(.CNT_W(4), .GATE_LOG2(GATE_LOG2), .SETTLE(SETTLE),
                   .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)) dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .mode_in_i(mode_in),
        .busy_o(b4_busy), .result_o(b4_result), .result_valid_o(b4_result_valid),
        .ovf_o(b4_ovf), .timeout_o(b4_timeout), .ro_clock_sel_o(b4_clock_sel),
        .ro_mode_o(b4_mode), .ro_shift_o(b4_shift),
        .ro_div_i(ro_div), .ro_done_i(ro_done));

    // Periodic ro_div, changing away from clk edges; period 0 holds it low.
    int div_per = 0;
    int ph      = 0;
    always @(posedge clk) begin
        #2;
        if (div_per < 2) begin
            ro_div = 1'b0;
        end else begin
            ph     = (ph + 1) % div_per;
            ro_div = (ph < div_per / 2);
        end
    end

    typedef struct {
        logic [CNT_W-1:0] res;
        logic             ovf;
        logic             tmo;
    } exp_t;

    exp_t sb[$];
    exp_t ex;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement. done_dly < 0 never raises ro_done. poke pulses start
    // in the middle of GATE. Returns busy cycles, shift cycles, cycles spent
    // in WAIT and whether ro_mode ever differed from the captured mode.
    task automatic run(input logic mode, input int done_dly, input bit poke,
                       output int bcyc, output int scyc, output int wcyc,
                       output bit mode_bad);
        int e;
        int s_edge;
        bit seen_busy;
        bcyc = 0; scyc = 0; wcyc = 0; mode_bad = 1'b0;
        s_edge = -1; seen_busy = 1'b0;
        start = 1'b1; mode_in = mode;
        @(posedge clk); #1;
        start = 1'b0; mode_in = 1'b0;
        e = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy) begin
                bcyc++;
                seen_busy = 1'b1;
                if (ro_mode !== mode) mode_bad = 1'b1;
            end
            if (ro_shift) begin
                scyc++;
                if (s_edge < 0) s_edge = e;
            end
            if (seen_busy && !busy) break;
            @(posedge clk); #1;
            e++;
            start = poke && (bcyc == SETTLE + 8);
            if (s_edge >= 0 && done_dly >= 0 && e == s_edge + 1 + done_dly) ro_done = 1'b1;
        end
        check("run_busy_end", 32'(busy), 32'(0));
        if (s_edge >= 0) wcyc = e - (s_edge + 1);
        start = 1'b0;
        ro_done = 1'b0;
    endtask

    task automatic settle_div(input int per);
        div_per = per;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_sb(input string tag);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
        end else begin
            ex = sb.pop_front();
            check({tag, "_result"},  32'(result),       32'(ex.res));
            check({tag, "_ovf"},     32'(ovf),          32'(ex.ovf));
            check({tag, "_timeout"}, 32'(timeout),      32'(ex.tmo));
            check({tag, "_valid"},   32'(result_valid), 32'(1));
        end
    endtask

    int  bc, sc, wc;
    bit  mb;

    initial begin
        reset = 1'b1; start = 1'b0; mode_in = 1'b0; ro_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outs", 32'({busy, result, result_valid, ovf, timeout,
                                 ro_clock_sel, ro_mode, ro_shift}), 32'(0));
        check("reset_outs4", 32'({b4_busy, b4_result, b4_result_valid, b4_ovf,
                                  b4_timeout, b4_clock_sel, b4_mode, b4_shift}), 32'(0));

        // Basic measurement: period 8 -> 8 edges in 64 cycles
        settle_div(8);
        sb.push_back('{res: 8'd8, ovf: 1'b0, tmo: 1'b0});
        run(1'b0, DONE_DLY, 1'b0, bc, sc, wc, mb);
        check_sb("basic");
        check("basic_shift_cycles", 32'(sc), 32'(1));
        check("basic_busy_cycles",  32'(bc), 32'(BUSY_RUN));
        check("basic_clock_sel",    32'(ro_clock_sel), 32'(0));

        // Toggle every cycle: 32 edges, wraps/saturates the 4-bit counter
        settle_div(2);
        sb.push_back('{res: 8'd32, ovf: 1'b0, tmo: 1'b0});
        run(1'b0, DONE_DLY, 1'b0, bc, sc, wc, mb);
        check_sb("fast8");
        check("ovf4_result", 32'(b4_result), 32'(OVF4_RES));
        check("ovf4_flag",   32'(b4_ovf),    32'(1));

        // Handshake timeout: ro_done never arrives
        settle_div(8);
        sb.push_back('{res: 8'd8, ovf: 1'b0, tmo: 1'b1});
        run(1'b0, -1, 1'b0, bc, sc, wc, mb);
        check_sb("tmo");
        check("tmo_wait_cycles", 32'(wc), 32'(TIMEOUT));
        check("tmo_busy_cycles", 32'(bc), 32'(SETTLE + GATE_LEN + 1 + TIMEOUT));

        // Start pulsed during GATE is ignored; mode captured once
        sb.push_back('{res: 8'd8, ovf: 1'b0, tmo: 1'b0});
        run(1'b1, DONE_DLY, 1'b1, bc, sc, wc, mb);
        check_sb("poke");
        check("poke_busy_cycles", 32'(bc), 32'(BUSY_RUN));
        check("poke_mode_held",   32'(mb), 32'(0));
        check("poke_mode_after",  32'(ro_mode), 32'(1));

        // Reset in the middle of GATE
        start = 1'b1; mode_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode_in = 1'b0;
        repeat (SETTLE + 20) @(posedge clk);
        #1;
        check("rst_pre_busy", 32'(busy), 32'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_outs", 32'({busy, result, result_valid, ovf, timeout,
                               ro_clock_sel, ro_mode, ro_shift}), 32'(0));

        // Fresh measurement after reset
        repeat (4) @(posedge clk);
        #1;
        sb.push_back('{res: 8'd8, ovf: 1'b0, tmo: 1'b0});
        run(1'b0, DONE_DLY, 1'b0, bc, sc, wc, mb);
        check_sb("fresh");
        check("fresh_busy_cycles", 32'(bc), 32'(BUSY_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
